// File: rtl/imem_loader_if.sv
// imem_loader_if: UART byte input, halt flag and instruction-memory/pipeline control
// outputs of the program loader; slave = loader side, master = host side.
`default_nettype none

interface imem_loader_if;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        i_halt;
   logic        o_write_en;
   logic [31:0] o_addr_wr;
   logic [31:0] o_data;
   logic        o_read_en;
   logic        o_clk_en;
   logic        o_busy;
   logic        o_error;

   modport slave (
      input  i_rx_data, i_rx_valid, i_halt,
      output o_write_en, o_addr_wr, o_data, o_read_en, o_clk_en, o_busy, o_error
   );

   modport master (
      output i_rx_data, i_rx_valid, i_halt,
      input  o_write_en, o_addr_wr, o_data, o_read_en, o_clk_en, o_busy, o_error
   );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: UART-driven program loader / run controller for the instruction memory.
// Rev 1.0 -- initial release.
`default_nettype none

module imem_loader #(
   parameter int MAX_WORDS      = 64,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic          i_clk,
   input  logic          i_reset,
   imem_loader_if.slave  bus
);

   localparam int IDX_W = $clog2(MAX_WORDS + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] C_CMD_LOAD = 8'h4C;
   localparam logic [7:0] C_CMD_RUN  = 8'h52;
   localparam logic [7:0] C_CMD_STEP = 8'h53;
   localparam logic [7:0] C_CMD_HALT = 8'h48;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_GET_COUNT = 2'd1,
      S_GET_BYTES = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  count_q;
   logic [IDX_W-1:0]  word_idx_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       shift_q;
   logic [TMR_W-1:0]  timer_q;
   logic              done_q;
   logic              write_en_q;
   logic [31:0]       addr_q;
   logic [31:0]       data_q;
   logic              read_en_q;
   logic              clk_en_q;
   logic              busy_q;
   logic              error_q;

   logic w_timeout;
   logic w_last_word;
   logic w_bad_count;

   assign w_timeout   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
   assign w_last_word = ((word_idx_q + IDX_W'(1)) == count_q);
   assign w_bad_count = (bus.i_rx_data == 8'd0) || (32'(bus.i_rx_data) > 32'(MAX_WORDS));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         timer_q    <= '0;
         done_q     <= 1'b0;
         write_en_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         read_en_q  <= 1'b1;
         clk_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         write_en_q <= 1'b0;
         error_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               clk_en_q <= 1'b0;
               if (bus.i_rx_valid) begin
                  case (bus.i_rx_data)
                     C_CMD_LOAD: begin
                        state_q   <= S_GET_COUNT;
                        busy_q    <= 1'b1;
                        read_en_q <= 1'b0;
                        timer_q   <= '0;
                     end
                     C_CMD_RUN: begin
                        state_q  <= S_RUN;
                        clk_en_q <= 1'b1;
                     end
                     C_CMD_STEP: clk_en_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            S_GET_COUNT: begin
               if (bus.i_rx_valid) begin
                  timer_q <= '0;
                  if (w_bad_count) begin
                     error_q   <= 1'b1;
                     state_q   <= S_IDLE;
                     busy_q    <= 1'b0;
                     read_en_q <= 1'b1;
                  end else begin
                     count_q    <= IDX_W'(bus.i_rx_data);
                     word_idx_q <= '0;
                     byte_idx_q <= '0;
                     done_q     <= 1'b0;
                     state_q    <= S_GET_BYTES;
                  end
               end else if (w_timeout) begin
                  error_q   <= 1'b1;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  read_en_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            S_GET_BYTES: begin
               // The final write pulse is still presented with busy high; leave afterwards.
               if (done_q) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  read_en_q <= 1'b1;
               end else if (bus.i_rx_valid) begin
                  timer_q    <= '0;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     write_en_q <= 1'b1;
                     data_q     <= {shift_q, bus.i_rx_data};
                     addr_q     <= {{(30 - IDX_W){1'b0}}, word_idx_q, 2'b00};
                     word_idx_q <= word_idx_q + IDX_W'(1);
                     done_q     <= w_last_word;
                  end else begin
                     shift_q <= {shift_q[15:0], bus.i_rx_data};
                  end
               end else if (w_timeout) begin
                  error_q   <= 1'b1;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  read_en_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            S_RUN: begin
               if (bus.i_halt || (bus.i_rx_valid && (bus.i_rx_data == C_CMD_HALT))) begin
                  state_q  <= S_IDLE;
                  clk_en_q <= 1'b0;
               end else begin
                  clk_en_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.o_write_en = write_en_q;
   assign bus.o_addr_wr  = addr_q;
   assign bus.o_data     = data_q;
   assign bus.o_read_en  = read_en_q;
   assign bus.o_clk_en   = clk_en_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a transaction-level loader model checked every cycle.
`default_nettype none

module tb_imem_loader;

   localparam int MAXW = 64;
   localparam int TMO  = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_loader_if bus ();

   imem_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: mode 0 idle, 1 awaiting count, 2 collecting bytes, 3 running.
   int          m_mode, m_timer, m_nwords, m_done;
   bit          m_fin;
   logic [7:0]  m_bq[$];
   logic        m_we, m_clk, m_err;
   logic [31:0] m_addr, m_data;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          n_err = 0;
   int          n_clk = 0;

   task automatic model_reset();
      m_mode = 0; m_timer = 0; m_nwords = 0; m_done = 0; m_fin = 0;
      m_bq.delete();
      m_we = 1'b0; m_clk = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
   endtask

   task automatic model_silence();
      m_timer++;
      if (m_timer == TMO) begin
         m_err  = 1'b1;
         m_mode = 0;
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit h);
      m_we  = 1'b0;
      m_err = 1'b0;
      case (m_mode)
         0: begin
            m_clk = 1'b0;
            if (v) begin
               if (d == 8'h4C) begin m_mode = 1; m_timer = 0; end
               else if (d == 8'h52) begin m_mode = 3; m_clk = 1'b1; end
               else if (d == 8'h53) m_clk = 1'b1;
            end
         end
         1: begin
            if (v) begin
               m_timer = 0;
               if (d == 8'd0 || int'(d) > MAXW) begin
                  m_err  = 1'b1;
                  m_mode = 0;
               end else begin
                  m_nwords = int'(d); m_done = 0; m_fin = 0;
                  m_bq.delete();
                  m_mode = 2;
               end
            end else model_silence();
         end
         2: begin
            if (m_fin) m_mode = 0;
            else if (v) begin
               m_timer = 0;
               m_bq.push_back(d);
               if (m_bq.size() == 4) begin
                  m_data = {m_bq[0], m_bq[1], m_bq[2], m_bq[3]};
                  m_addr = 32'(m_done * 4);
                  m_we   = 1'b1;
                  m_done++;
                  m_bq.delete();
                  if (m_done == m_nwords) m_fin = 1;
               end
            end else model_silence();
         end
         default: begin
            if (h || (v && d == 8'h48)) begin m_mode = 0; m_clk = 1'b0; end
            else m_clk = 1'b1;
         end
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] dat);
      if (idx < wr_addr.size()) begin
         check($sformatf("wr%0d_addr", idx), wr_addr[idx], a);
         check($sformatf("wr%0d_data", idx), wr_data[idx], dat);
      end else begin
         check($sformatf("wr%0d_present", idx), 32'(wr_addr.size()), 32'(idx + 1));
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin : cmp_loop
         logic [68:0] act, exp;
         logic        busy;
         @(negedge clk);
         busy = (m_mode == 1) || (m_mode == 2);
         act = {bus.o_write_en, bus.o_addr_wr, bus.o_data, bus.o_read_en,
                bus.o_clk_en, bus.o_busy, bus.o_error};
         exp = {m_we, m_addr, m_data, ~busy, m_clk, busy, m_err};
         tests_run++;
         if (act !== exp) begin
            tests_failed++;
            $display("FAIL cycle_cmp t=%0t got we=%0b addr=%0h data=%0h rd=%0b ce=%0b busy=%0b err=%0b, expected we=%0b addr=%0h data=%0h rd=%0b ce=%0b busy=%0b err=%0b",
                     $time, act[68], act[67:36], act[35:4], act[3], act[2], act[1], act[0],
                     exp[68], exp[67:36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
         end
         if (bus.o_write_en === 1'b1) begin
            wr_addr.push_back(bus.o_addr_wr);
            wr_data.push_back(bus.o_data);
         end
         if (bus.o_error === 1'b1)  n_err++;
         if (bus.o_clk_en === 1'b1) n_clk++;
      end
   end

   task automatic cyc(input bit v, input logic [7:0] d, input bit h);
      bus.i_rx_valid = v;
      bus.i_rx_data  = d;
      bus.i_halt     = h;
      @(posedge clk);
      if (rst_n) model_step(v, d, h);
      else       model_reset();
      #1;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      bus.i_halt     = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},    32'(bus.o_write_en), 32'd0);
      check({tag, "_addr"},  bus.o_addr_wr,       32'd0);
      check({tag, "_data"},  bus.o_data,          32'd0);
      check({tag, "_rd"},    32'(bus.o_read_en),  32'd1);
      check({tag, "_ce"},    32'(bus.o_clk_en),   32'd0);
      check({tag, "_busy"},  32'(bus.o_busy),     32'd0);
      check({tag, "_err"},   32'(bus.o_error),    32'd0);
   endtask

   initial begin : stim
      int e0, c0, w0;
      logic [7:0] prog[10];
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      bus.i_halt     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      // Two-word load with gaps between bytes.
      prog = '{8'h4C, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
      foreach (prog[i]) begin send(prog[i]); idle(2); end
      idle(3);
      check("load2_nwr", 32'(wr_addr.size()), 32'd2);
      chk_wr(0, 32'h0, 32'hDEADBEEF);
      chk_wr(1, 32'h4, 32'h00000001);
      check("load2_rd", 32'(bus.o_read_en), 32'd1);

      // Invalid counts.
      e0 = n_err;
      send(8'h4C); send(8'h00); idle(3);
      send(8'h4C); send(8'h41); idle(3);
      check("badcnt_err", 32'(n_err - e0), 32'd2);
      check("badcnt_nwr", 32'(wr_addr.size()), 32'd2);

      // Timeout mid-word.
      e0 = n_err;
      send(8'h4C); send(8'h01); send(8'h11); send(8'h22);
      idle(TMO + 5);
      check("tmo_err", 32'(n_err - e0), 32'd1);
      check("tmo_nwr", 32'(wr_addr.size()), 32'd2);
      check("tmo_busy", 32'(bus.o_busy), 32'd0);

      // N = MAX_WORDS accepted, then abandoned; and a timeout while awaiting count.
      e0 = n_err;
      send(8'h4C); send(8'h40); idle(2);
      check("nmax_busy", 32'(bus.o_busy), 32'd1);
      idle(TMO + 2);
      send(8'h4C); idle(TMO + 3);
      check("nmax_cnt_tmo_err", 32'(n_err - e0), 32'd2);

      // Run / halt / single step; halt outside RUN is ignored.
      c0 = n_clk;
      send(8'h52); idle(10); cyc(1'b0, 8'h00, 1'b1); idle(3);
      send(8'h53); idle(3);
      cyc(1'b0, 8'h00, 1'b1); idle(2);
      check("run_step_ce", 32'(n_clk - c0), 32'd12);
      c0 = n_clk;
      send(8'h52); idle(2); send(8'h48); idle(2);
      send(8'h52); cyc(1'b1, 8'h48, 1'b1); idle(2);
      check("run_hbyte_ce", 32'(n_clk - c0), 32'd4);

      // Asynchronous reset mid-word, then a fresh load from address 0.
      w0 = wr_addr.size();
      send(8'h4C); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(8'h4C); send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      idle(3);
      check("rst_reload_nwr", 32'(wr_addr.size() - w0), 32'd1);
      chk_wr(w0, 32'h0, 32'h01020304);

      // Back-to-back strobes, three words.
      w0 = wr_addr.size();
      send(8'h4C); send(8'h03);
      for (int b = 0; b < 12; b++) send(8'(b));
      idle(3);
      check("b2b_nwr", 32'(wr_addr.size() - w0), 32'd3);
      chk_wr(w0,     32'h0, 32'h00010203);
      chk_wr(w0 + 1, 32'h4, 32'h04050607);
      chk_wr(w0 + 2, 32'h8, 32'h08090A0B);
      check("b2b_rd", 32'(bus.o_read_en), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
